pio_event_sequencer: RTL and testbench

- Avalon-MM master controller that owns one edge-capture input PIO (button/mode PIO: data reg 0, irq_mask reg 2, edge_capture reg 3, 1-cycle registered readdata, irq output).
- Arms the PIO mask, services its irq in hardware, clears edge_capture, samples the pin level, and pushes timestamped events into an internal FIFO.
- Frees the Nios CPU from per-edge ISR work; CPU or downstream logic drains events through a valid/ready port.

---
 rtl/pio_evt_pkg.sv | 26 ++
 rtl/pio_evt_fifo.sv | 63 ++++++
 rtl/pio_event_sequencer.sv | 169 ++++++++++++++++
 tb/tb_pio_event_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_evt_pkg.sv
// Shared state encoding and PIO register map for the PIO event sequencer.
package pio_evt_pkg;

    // Sequencer states, in the order a normal service pass visits them.
    typedef enum logic [3:0] {
        OFF,
        MASK_ON,
        IDLE,
        RD_CAP,
        CHK_CAP,
        CLR_CAP,
        RD_DAT,
        PUSH,
        MASK_OFF
    } state_t;

    // PIO register addresses (word offsets).
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    // irq_mask values: only bit 0 is used by the one-pin PIO.
    localparam logic [31:0] MASK_ARM    = 32'd1;
    localparam logic [31:0] MASK_DISARM = 32'd0;

endpackage

// File: rtl/pio_evt_fifo.sv
// Synchronous show-ahead FIFO with occupancy count. A push while full is
// dropped even if a pop happens in the same cycle.
module pio_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 17,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             full,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count != '0);
    assign full    = (count == FULL_COUNT);
    assign do_push = push & ~full;
    assign do_pop  = pop & valid;
    assign head    = mem[rd_ptr];

    // Storage write.
    // NOTE: the data array has no reset; only pointers and count need one, and
    // leaving the array unreset lets it map onto plain RAM/register files.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally modulo DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pio_event_sequencer.sv
// Avalon-MM master that arms an edge-capture PIO, services its irq in
// hardware and queues {timestamp, level} events for a valid/ready consumer.
module pio_event_sequencer
    import pio_evt_pkg::*;
#(
    parameter int  FIFO_DEPTH = 8,
    parameter int  TS_W       = 16,
    localparam int EVT_W      = TS_W + 1,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pio_irq,
    output logic [1:0]       pio_address,
    output logic             pio_chipselect,
    output logic             pio_write_n,
    output logic [31:0]      pio_writedata,
    input  logic [31:0]      pio_readdata,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [EVT_W-1:0] evt_data,
    output logic [CNT_W-1:0] evt_count,
    output logic             overflow,
    input  logic             ovf_clr,
    output logic             busy
);

    state_t          state;
    state_t          state_next;
    logic [TS_W-1:0] timestamp;
    logic [TS_W-1:0] ts_snap;
    logic            snap_en;
    logic            push;
    logic            fifo_full;
    logic            unused_readdata;

    // Only bit 0 of the PIO carries information for a one-pin PIO.
    assign unused_readdata = ^pio_readdata[31:1];

    assign busy = (state != IDLE) && (state != OFF);

    // Free-running timestamp, wraps from all-ones to zero.
    // NOTE: sequential state is always assigned with <= so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timestamp <= '0;
        end else begin
            timestamp <= timestamp + 1'b1;
        end
    end

    // Timestamp snapshot taken at the cycle the irq is accepted in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_snap <= '0;
        end else if (snap_en) begin
            ts_snap <= timestamp;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= OFF;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and bus outputs: one bus access per state-cycle, decoded from state.
    // NOTE: every output of this block gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        state_next     = state;
        pio_chipselect = 1'b0;
        pio_write_n    = 1'b1;
        pio_address    = ADDR_DATA;
        pio_writedata  = '0;
        snap_en        = 1'b0;
        push           = 1'b0;

        case (state)
            OFF: begin
                if (enable) begin
                    state_next = MASK_ON;
                end
            end
            MASK_ON: begin
                pio_chipselect = 1'b1;
                pio_write_n    = 1'b0;
                pio_address    = ADDR_MASK;
                pio_writedata  = MASK_ARM;
                state_next     = IDLE;
            end
            IDLE: begin
                // Disabling wins over a pending irq.
                if (!enable) begin
                    state_next = MASK_OFF;
                end else if (pio_irq) begin
                    snap_en    = 1'b1;
                    state_next = RD_CAP;
                end
            end
            RD_CAP: begin
                pio_chipselect = 1'b1;
                pio_address    = ADDR_EDGE;
                state_next     = CHK_CAP;
            end
            CHK_CAP: begin
                // A clear capture bit means the irq was spurious.
                state_next = pio_readdata[0] ? CLR_CAP : IDLE;
            end
            CLR_CAP: begin
                pio_chipselect = 1'b1;
                pio_write_n    = 1'b0;
                pio_address    = ADDR_EDGE;
                state_next     = RD_DAT;
            end
            RD_DAT: begin
                pio_chipselect = 1'b1;
                pio_address    = ADDR_DATA;
                state_next     = PUSH;
            end
            PUSH: begin
                push       = 1'b1;
                state_next = IDLE;
            end
            MASK_OFF: begin
                pio_chipselect = 1'b1;
                pio_write_n    = 1'b0;
                pio_address    = ADDR_MASK;
                pio_writedata  = MASK_DISARM;
                state_next     = OFF;
            end
            default: begin
                state_next = OFF;
            end
        endcase
    end

    // Sticky overflow: a dropped push wins over a clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push && fifo_full) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    pio_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({ts_snap, pio_readdata[0]}),
        .pop       (evt_ready),
        .head      (evt_data),
        .valid     (evt_valid),
        .full      (fifo_full),
        .count     (evt_count)
    );

endmodule

// File: tb/tb_pio_event_sequencer.sv
// Self-checking bench for pio_event_sequencer: a behavioural PIO slave, a
// transaction-level event scoreboard, table-driven service sequences,
// directed corner cases and a randomized phase.
`timescale 1ns/1ps
module tb_pio_event_sequencer;

    localparam int FIFO_DEPTH = 8;
    localparam int TS_W       = 16;
    localparam int EVT_W      = TS_W + 1;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             pio_irq;
    logic [1:0]       pio_address;
    logic             pio_chipselect;
    logic             pio_write_n;
    logic [31:0]      pio_writedata;
    logic [31:0]      pio_readdata;
    logic             evt_valid;
    logic             evt_ready;
    logic [EVT_W-1:0] evt_data;
    logic [CNT_W-1:0] evt_count;
    logic             overflow;
    logic             ovf_clr;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pio_event_sequencer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .TS_W       (TS_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .pio_irq        (pio_irq),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .pio_readdata   (pio_readdata),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_data       (evt_data),
        .evt_count      (evt_count),
        .overflow       (overflow),
        .ovf_clr        (ovf_clr),
        .busy           (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural PIO slave ----------------
    logic pin;
    logic spur_irq;
    logic pio_mask;
    logic pio_cap;
    logic pin_d;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pio_mask     <= 1'b0;
            pio_cap      <= 1'b0;
            pin_d        <= 1'b0;
            pio_readdata <= 32'h0;
        end else begin
            pin_d        <= pin;
            pio_readdata <= 32'h0;
            if (pio_chipselect && pio_write_n) begin
                case (pio_address)
                    2'd0:    pio_readdata <= {31'b0, pin};
                    2'd2:    pio_readdata <= {31'b0, pio_mask};
                    2'd3:    pio_readdata <= {31'b0, pio_cap};
                    default: pio_readdata <= 32'h0;
                endcase
            end
            if (pio_chipselect && !pio_write_n && pio_address == 2'd2)
                pio_mask <= pio_writedata[0];
            if (pin && !pin_d)
                pio_cap <= 1'b1;
            else if (pio_chipselect && !pio_write_n && pio_address == 2'd3)
                pio_cap <= 1'b0;
        end
    end

    assign pio_irq = (pio_mask & pio_cap) | spur_irq;

    // Reference clock count since reset: the timestamp the DUT should hold.
    int unsigned ts_now;
    always @(posedge clk or posedge reset) begin
        if (reset) ts_now <= 0;
        else       ts_now <= ts_now + 1;
    end

    // ---------------- bus log and event scoreboard ----------------
    typedef struct packed {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
    } acc_t;

    function automatic acc_t acc(input logic wr, input logic [1:0] a, input logic [31:0] d);
        acc_t r;
        r.wr   = wr;
        r.addr = a;
        r.data = d;
        return r;
    endfunction

    acc_t             bus_log[$];
    logic [EVT_W-1:0] model_q[$];
    logic             model_ovf;
    logic             push_pend;
    logic [EVT_W-1:0] pend_ev;
    logic [TS_W-1:0]  pend_ts;
    bit               mdl_full;
    bit               mdl_set;

    // Each event is what the bus transactions imply: the capture read fixes the
    // timestamp (one cycle before it), the data read fixes the level, and the
    // event lands in the queue one cycle after the data read.
    always @(negedge clk) begin
        if (reset) begin
            model_q.delete();
            model_ovf = 1'b0;
            push_pend = 1'b0;
        end else begin
            check("evt_count", evt_count, model_q.size());
            check("evt_valid", evt_valid, model_q.size() != 0);
            if (model_q.size() != 0) check("evt_data", evt_data, model_q[0]);
            check("overflow", overflow, model_ovf);

            if (pio_chipselect) bus_log.push_back(acc(!pio_write_n, pio_address, pio_writedata));

            mdl_full = (model_q.size() == FIFO_DEPTH);
            mdl_set  = 1'b0;
            if (evt_ready && model_q.size() != 0) void'(model_q.pop_front());
            if (push_pend) begin
                if (!mdl_full) model_q.push_back(pend_ev);
                else           mdl_set = 1'b1;
            end
            if (mdl_set)      model_ovf = 1'b1;
            else if (ovf_clr) model_ovf = 1'b0;

            if (pio_chipselect && pio_write_n && pio_address == 2'd3)
                pend_ts = TS_W'(ts_now - 1);
            push_pend = pio_chipselect && pio_write_n && pio_address == 2'd0;
            pend_ev   = {pend_ts, pin};
        end
    end

    task automatic wait_access(input logic wr, input logic [1:0] a, input string name);
        int n = 0;
        while (!(pio_chipselect && (pio_write_n == !wr) && pio_address == a) && n < 50) begin
            tick();
            n++;
        end
        check({name, " reached"}, n < 50, 1'b1);
    endtask

    // ---------------- per-cycle service vectors ----------------
    typedef struct {
        logic        spur;
        logic        cs;
        logic        wn;
        logic [1:0]  addr;
        logic        chk_addr;
        logic [31:0] wdata;
        logic        valid;
        logic        bsy;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TS_W-1:0] prev_ts;
        int              cnt0;
        int              guard;

        // spur  cs    wn    addr  chk   wdata  valid bsy
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'd0, 1'b0, 1'b0}; // N: IDLE sees irq
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 32'd0, 1'b0, 1'b1}; // read edge_capture
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'd0, 1'b0, 1'b1}; // check capture
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 32'd0, 1'b0, 1'b1}; // clear capture
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 32'd0, 1'b0, 1'b1}; // read data
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'd0, 1'b0, 1'b1}; // push
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'd0, 1'b1, 1'b0}; // N+6: event visible
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'd0, 1'b1, 1'b0}; // spurious irq seen
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 32'd0, 1'b1, 1'b1}; // read capture = 0
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'd0, 1'b1, 1'b1}; // check -> IDLE
        vecs[10] = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'd0, 1'b1, 1'b0}; // back in IDLE

        reset = 1'b1; enable = 1'b0; evt_ready = 1'b0; ovf_clr = 1'b0;
        pin = 1'b0; spur_irq = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state.
        check("rst cs", pio_chipselect, 1'b0);
        check("rst write_n", pio_write_n, 1'b1);
        check("rst address", pio_address, 2'd0);
        check("rst writedata", pio_writedata, 32'd0);
        check("rst valid", evt_valid, 1'b0);
        check("rst count", evt_count, 0);
        check("rst overflow", overflow, 1'b0);
        check("rst busy", busy, 1'b0);

        // Enable: exactly one mask-arm write, then a quiet bus.
        bus_log.delete();
        enable = 1'b1;
        repeat (8) tick();
        check("arm access count", bus_log.size(), 1);
        if (bus_log.size() >= 1) check("arm access", bus_log[0], acc(1'b1, 2'd2, 32'd1));

        // Normal service with ts 0x0010, then a spurious irq.
        guard = 0;
        while (ts_now != 15 && guard < 100) begin tick(); guard++; end
        check("align ts", ts_now, 15);
        bus_log.delete();
        for (int i = 0; i < 11; i++) begin
            if (i == 0 || vecs[i].spur != vecs[i-1].spur) begin
                if (vecs[i].spur) spur_irq = 1'b1;
                else begin pin = 1'b1; tick(); end
            end
            check($sformatf("vec%0d cs", i), pio_chipselect, vecs[i].cs);
            check($sformatf("vec%0d write_n", i), pio_write_n, vecs[i].wn);
            if (vecs[i].chk_addr) begin
                check($sformatf("vec%0d address", i), pio_address, vecs[i].addr);
                check($sformatf("vec%0d writedata", i), pio_writedata, vecs[i].wdata);
            end
            check($sformatf("vec%0d evt_valid", i), evt_valid, vecs[i].valid);
            check($sformatf("vec%0d busy", i), busy, vecs[i].bsy);
            tick();
            spur_irq = 1'b0;
        end
        check("first event data", evt_data, 17'h00021);
        check("first event count", evt_count, 1);
        check("service access count", bus_log.size(), 4);
        if (bus_log.size() >= 4) begin
            check("access0", bus_log[0], acc(1'b0, 2'd3, 32'd0));
            check("access1", bus_log[1], acc(1'b1, 2'd3, 32'd0));
            check("access2", bus_log[2], acc(1'b0, 2'd0, 32'd0));
            check("access3", bus_log[3], acc(1'b0, 2'd3, 32'd0));
        end
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        pin = 1'b0; tick();

        // Nine edges into an eight-deep FIFO with no draining.
        for (int e = 0; e < 9; e++) begin
            pin = 1'b1; tick(); pin = 1'b0;
            repeat (10) tick();
        end
        check("full count", evt_count, 8);
        check("overflow set", overflow, 1'b1);
        prev_ts = '0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("pop%0d valid", i), evt_valid, 1'b1);
            check($sformatf("pop%0d count", i), evt_count, 8 - i);
            check($sformatf("pop%0d level", i), evt_data[0], 1'b0);
            if (i > 0) check($sformatf("pop%0d ts step", i), TS_W'(evt_data[EVT_W-1:1] - prev_ts), 11);
            prev_ts = evt_data[EVT_W-1:1];
            evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        end
        check("drained count", evt_count, 0);
        check("overflow held", overflow, 1'b1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("overflow cleared", overflow, 1'b0);

        // Disable during the data read: finish the event, disarm, go OFF.
        bus_log.delete();
        pin = 1'b1; tick(); pin = 1'b0;
        wait_access(1'b0, 2'd0, "rd_dat");
        cnt0 = int'(evt_count);
        enable = 1'b0;
        repeat (6) tick();
        check("disable push done", evt_count, cnt0 + 1);
        check("disable busy", busy, 1'b0);
        check("disable access count", bus_log.size(), 4);
        if (bus_log.size() >= 4) check("disarm access", bus_log[3], acc(1'b1, 2'd2, 32'd0));
        spur_irq = 1'b1;
        repeat (10) tick();
        spur_irq = 1'b0;
        check("off ignores irq", bus_log.size(), 4);
        check("off busy", busy, 1'b0);

        // Reset in the middle of the capture clear.
        enable = 1'b1;
        pin = 1'b1; tick(); pin = 1'b0;
        wait_access(1'b1, 2'd3, "clr_cap");
        reset = 1'b1;
        #1;
        check("mid rst cs", pio_chipselect, 1'b0);
        check("mid rst write_n", pio_write_n, 1'b1);
        check("mid rst busy", busy, 1'b0);
        check("mid rst valid", evt_valid, 1'b0);
        check("mid rst count", evt_count, 0);
        repeat (2) tick();
        reset = 1'b0;
        guard = 0;
        while (ts_now != 15 && guard < 100) begin tick(); guard++; end
        pin = 1'b1;
        repeat (7) tick();
        check("post rst valid", evt_valid, 1'b1);
        check("post rst ts restart", evt_data, 17'h00021);
        pin = 1'b0;
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;

        // Randomized traffic against the scoreboard.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            if ($urandom_range(0, 5) == 0) pin = ~pin;
            evt_ready = (c < 1500) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 0);
            ovf_clr   = ($urandom_range(0, 49) == 0);
            spur_irq  = ($urandom_range(0, 99) == 0);
            tick();
        end
        enable = 1'b0; pin = 1'b0; spur_irq = 1'b0; ovf_clr = 1'b0; evt_ready = 1'b1;
        repeat (30) tick();
        check("final drained", evt_count, 0);
        check("final busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
